// File: rtl/table_access_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// table_access_arbiter_pkg
// Shared definitions for the table access arbiter: response-steering tag
// encodings and the log2 helper used to size the starvation counter.
// ----------------------------------------------------------------------------
package table_access_arbiter_pkg;

  // Owner of the memory slot granted in a given cycle; travels with the
  // access so the response pipeline knows where the read data belongs.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_LOOKUP = 2'd1,
    TAG_REG_RD = 2'd2,
    TAG_REG_WR = 2'd3
  } tag_e;

  // Largest starvation limit the counter is sized for.
  localparam int STARVE_LIMIT_MAX = 255;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int LOG2_FUNC(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/table_access_arbiter_rsp_pipe.sv
// ----------------------------------------------------------------------------
// table_access_arbiter_rsp_pipe (table_rsp_pipe)
// Two-stage tag pipeline that turns granted accesses into responses.
//   Stage 1: registered tag of the access granted last cycle (memory data is
//            valid on i_mem_rdata during this stage).
//   Stage 2: registered outputs; read data captured from i_mem_rdata.
// Ports:
//   clk, reset            clock, async active-low reset
//   i_tag                 tag of the access granted this cycle
//   i_mem_rdata           memory read data (valid one cycle after a read)
//   o_lookup_rsp_vld/data lookup response, grant + 2
//   o_table_rd_ack/data   register read completion, grant + 2
//   o_table_wr_ack        register write completion, grant + 1
// ----------------------------------------------------------------------------
module table_access_arbiter_rsp_pipe
  import table_access_arbiter_pkg::*;
#(
  parameter int TABLE_ENTRY_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  tag_e                         i_tag,
  input  logic [TABLE_ENTRY_WIDTH-1:0] i_mem_rdata,
  output logic                         o_lookup_rsp_vld,
  output logic [TABLE_ENTRY_WIDTH-1:0] o_lookup_rsp_data,
  output logic                         o_table_rd_ack,
  output logic [TABLE_ENTRY_WIDTH-1:0] o_table_rd_data,
  output logic                         o_table_wr_ack
);

  tag_e r_tag_s1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_s1          <= TAG_NONE;
      o_lookup_rsp_vld  <= 1'b0;
      o_lookup_rsp_data <= '0;
      o_table_rd_ack    <= 1'b0;
      o_table_rd_data   <= '0;
      o_table_wr_ack    <= 1'b0;
    end else begin
      r_tag_s1         <= i_tag;
      // A write needs no data back, so it completes out of stage 1.
      o_table_wr_ack   <= (i_tag == TAG_REG_WR);
      o_lookup_rsp_vld <= (r_tag_s1 == TAG_LOOKUP);
      o_table_rd_ack   <= (r_tag_s1 == TAG_REG_RD);
      // Data registers hold their last value between responses.
      if (r_tag_s1 == TAG_LOOKUP) o_lookup_rsp_data <= i_mem_rdata;
      if (r_tag_s1 == TAG_REG_RD) o_table_rd_data   <= i_mem_rdata;
    end
  end

endmodule

// File: rtl/table_access_arbiter.sv
// ----------------------------------------------------------------------------
// table_access_arbiter
// Shares one single-port synchronous table memory between the datapath lookup
// engine (priority) and the register-side read/write port. A starvation
// counter forces a pending register access through after STARVE_LIMIT denied
// cycles.
// Ports:
//   clk, reset                      clock, async active-low reset
//   lookup_req/addr, lookup_gnt     lookup request and combinational grant
//   lookup_rsp_vld/data             lookup response, grant + 2
//   table_rd_req/addr/ack/data      register read (level req, ack pulse)
//   table_wr_req/addr/data/ack      register write (level req, ack pulse)
//   mem_en/we/addr/wdata            combinational memory controls
//   mem_rdata                       memory read data, one cycle after read
// ----------------------------------------------------------------------------
module table_access_arbiter
  import table_access_arbiter_pkg::*;
#(
  parameter int TABLE_ADDR_WIDTH  = 8,
  parameter int TABLE_ENTRY_WIDTH = 32,
  parameter int STARVE_LIMIT      = 8   // 1..STARVE_LIMIT_MAX
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         lookup_req,
  input  logic [TABLE_ADDR_WIDTH-1:0]  lookup_addr,
  output logic                         lookup_gnt,
  output logic                         lookup_rsp_vld,
  output logic [TABLE_ENTRY_WIDTH-1:0] lookup_rsp_data,
  input  logic                         table_rd_req,
  input  logic [TABLE_ADDR_WIDTH-1:0]  table_rd_addr,
  output logic                         table_rd_ack,
  output logic [TABLE_ENTRY_WIDTH-1:0] table_rd_data,
  input  logic                         table_wr_req,
  input  logic [TABLE_ADDR_WIDTH-1:0]  table_wr_addr,
  input  logic [TABLE_ENTRY_WIDTH-1:0] table_wr_data,
  output logic                         table_wr_ack,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [TABLE_ADDR_WIDTH-1:0]  mem_addr,
  output logic [TABLE_ENTRY_WIDTH-1:0] mem_wdata,
  input  logic [TABLE_ENTRY_WIDTH-1:0] mem_rdata
);

  localparam int STARVE_CNT_W = LOG2_FUNC(STARVE_LIMIT + 1);
  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  logic                    r_reg_busy;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  tag_e                    w_grant;
  logic                    w_reg_pend;
  logic                    w_force;
  logic                    w_reg_grant;
  logic                    w_ack_now;

  // The busy guard keeps a request still high in its ack cycle from being
  // served a second time.
  assign w_reg_pend  = (table_rd_req || table_wr_req) && !r_reg_busy;
  assign w_force     = w_reg_pend && (r_starve_cnt == STARVE_MAX);
  assign w_reg_grant = (w_grant == TAG_REG_RD) || (w_grant == TAG_REG_WR);
  assign w_ack_now   = table_rd_ack || table_wr_ack;
  assign lookup_gnt  = (w_grant == TAG_LOOKUP);

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_grant = TAG_NONE;
    // Nothing is granted while reset is held, keeping the memory idle.
    if (reset) begin
      if (w_force)         w_grant = table_wr_req ? TAG_REG_WR : TAG_REG_RD;
      else if (lookup_req) w_grant = TAG_LOOKUP;
      else if (w_reg_pend) w_grant = table_wr_req ? TAG_REG_WR : TAG_REG_RD;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_grant)
      TAG_LOOKUP: begin
        mem_en   = 1'b1;
        mem_addr = lookup_addr;
      end
      TAG_REG_RD: begin
        mem_en   = 1'b1;
        mem_addr = table_rd_addr;
      end
      TAG_REG_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = table_wr_addr;
        mem_wdata = table_wr_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_busy   <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      if (w_reg_grant)    r_reg_busy <= 1'b1;
      else if (w_ack_now) r_reg_busy <= 1'b0;

      if (w_reg_pend && !w_reg_grant) begin
        if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  table_access_arbiter_rsp_pipe #(
    .TABLE_ENTRY_WIDTH (TABLE_ENTRY_WIDTH)
  ) u_rsp_pipe (
    .clk               (clk),
    .reset             (reset),
    .i_tag             (w_grant),
    .i_mem_rdata       (mem_rdata),
    .o_lookup_rsp_vld  (lookup_rsp_vld),
    .o_lookup_rsp_data (lookup_rsp_data),
    .o_table_rd_ack    (table_rd_ack),
    .o_table_rd_data   (table_rd_data),
    .o_table_wr_ack    (table_wr_ack)
  );

endmodule

// File: tb/tb_table_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_table_access_arbiter
// Directed test of table_access_arbiter against a behavioural single-port
// synchronous memory. Unwritten memory locations read back a fixed pattern:
// 0x12 holds 0xDEADBEEF, every other address A holds {4{A}}.
// ----------------------------------------------------------------------------
module tb_table_access_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          lookup_req;
  logic [AW-1:0] lookup_addr;
  logic          lookup_gnt;
  logic          lookup_rsp_vld;
  logic [DW-1:0] lookup_rsp_data;
  logic          table_rd_req;
  logic [AW-1:0] table_rd_addr;
  logic          table_rd_ack;
  logic [DW-1:0] table_rd_data;
  logic          table_wr_req;
  logic [AW-1:0] table_wr_addr;
  logic [DW-1:0] table_wr_data;
  logic          table_wr_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  table_access_arbiter #(
    .TABLE_ADDR_WIDTH  (AW),
    .TABLE_ENTRY_WIDTH (DW),
    .STARVE_LIMIT      (SL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_req      (lookup_req),
    .lookup_addr     (lookup_addr),
    .lookup_gnt      (lookup_gnt),
    .lookup_rsp_vld  (lookup_rsp_vld),
    .lookup_rsp_data (lookup_rsp_data),
    .table_rd_req    (table_rd_req),
    .table_rd_addr   (table_rd_addr),
    .table_rd_ack    (table_rd_ack),
    .table_rd_data   (table_rd_data),
    .table_wr_req    (table_wr_req),
    .table_wr_addr   (table_wr_addr),
    .table_wr_data   (table_wr_data),
    .table_wr_ack    (table_wr_ack),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  // Behavioural memory: synchronous single port, read data one cycle later.
  // NOTE: the storage array has no reset; a written flag selects between
  // written data and the fixed power-up pattern.
  logic [DW-1:0] mem_q   [256];
  bit            mem_wrt [256];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 8'h12) ? 32'hDEADBEEF : {4{a}};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_q[mem_addr]   <= mem_wdata;
        mem_wrt[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= mem_wrt[mem_addr] ? mem_q[mem_addr] : init_val(mem_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  // Count consecutive cycles the lookup wins while a register read waits.
  // Returns with the simulation positioned in the first non-lookup cycle.
  task automatic count_denials(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!lookup_gnt) break;
      n++;
      cyc();
      settle();
    end
  endtask

  logic [DW-1:0] b2b_exp [3];
  int            n_deny;

  initial begin
    b2b_exp[0] = 32'h01010101;
    b2b_exp[1] = 32'h02020202;
    b2b_exp[2] = 32'h03030303;

    // ---------------- reset state ----------------
    reset         = 1'b0;
    lookup_req    = 1'b1;
    lookup_addr   = 8'h12;
    table_rd_req  = 1'b0;
    table_rd_addr = '0;
    table_wr_req  = 1'b0;
    table_wr_addr = '0;
    table_wr_data = '0;
    #12;
    check("rst_gnt",      32'(lookup_gnt), 32'd0);
    check("rst_mem_en",   32'(mem_en), 32'd0);
    check("rst_mem_we",   32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rsp_vld",  32'(lookup_rsp_vld), 32'd0);
    check("rst_rd_ack",   32'(table_rd_ack), 32'd0);
    check("rst_wr_ack",   32'(table_wr_ack), 32'd0);
    check("rst_rsp_data", lookup_rsp_data, 32'd0);
    lookup_req = 1'b0;
    cyc();
    reset = 1'b1;

    // ---------------- single lookup ----------------
    cyc(); lookup_req = 1'b1; lookup_addr = 8'h12; settle();
    check("t1_gnt",      32'(lookup_gnt), 32'd1);
    check("t1_mem_en",   32'(mem_en), 32'd1);
    check("t1_mem_we",   32'(mem_we), 32'd0);
    check("t1_mem_addr", 32'(mem_addr), 32'h12);
    cyc(); lookup_req = 1'b0; settle();
    check("t1_vld_g1",   32'(lookup_rsp_vld), 32'd0);
    cyc(); settle();
    check("t1_vld_g2",   32'(lookup_rsp_vld), 32'd1);
    check("t1_data",     lookup_rsp_data, 32'hDEADBEEF);
    check("t1_no_rdack", 32'(table_rd_ack), 32'd0);
    check("t1_no_wrack", 32'(table_wr_ack), 32'd0);
    cyc(); settle();
    check("t1_vld_g3",   32'(lookup_rsp_vld), 32'd0);

    // ---------------- register write then read ----------------
    cyc(); table_wr_req = 1'b1; table_wr_addr = 8'h05; table_wr_data = 32'h0000CAFE; settle();
    check("t2_wr_en",    32'(mem_en), 32'd1);
    check("t2_wr_we",    32'(mem_we), 32'd1);
    check("t2_wr_addr",  32'(mem_addr), 32'h05);
    check("t2_wr_wdata", mem_wdata, 32'h0000CAFE);
    cyc(); settle();
    check("t2_wr_ack",   32'(table_wr_ack), 32'd1);
    check("t2_no_dup_wr", 32'(mem_en), 32'd0);
    table_wr_req = 1'b0;
    cyc(); table_rd_req = 1'b1; table_rd_addr = 8'h05; settle();
    check("t2_wr_ack_once", 32'(table_wr_ack), 32'd0);
    check("t2_rd_en",    32'(mem_en), 32'd1);
    check("t2_rd_we",    32'(mem_we), 32'd0);
    check("t2_rd_addr",  32'(mem_addr), 32'h05);
    cyc(); settle();
    check("t2_rd_ack_g1", 32'(table_rd_ack), 32'd0);
    check("t2_busy_g1",  32'(mem_en), 32'd0);
    cyc(); settle();
    check("t2_rd_ack",   32'(table_rd_ack), 32'd1);
    check("t2_rd_data",  table_rd_data, 32'h0000CAFE);
    check("t2_no_dup_rd", 32'(mem_en), 32'd0);
    table_rd_req = 1'b0;
    cyc(); settle();
    check("t2_rd_ack_once", 32'(table_rd_ack), 32'd0);

    // ---------------- starvation under continuous lookups ----------------
    cyc(); lookup_req = 1'b1; lookup_addr = 8'h01; table_rd_req = 1'b1; table_rd_addr = 8'h12; settle();
    count_denials(n_deny);
    check("t3_denials",   32'(n_deny), 32'(SL));
    check("t3_force_gnt", 32'(lookup_gnt), 32'd0);
    check("t3_force_en",  32'(mem_en), 32'd1);
    check("t3_force_addr", 32'(mem_addr), 32'h12);
    cyc(); settle();
    check("t3_resume",    32'(lookup_gnt), 32'd1);
    check("t3_resume_addr", 32'(mem_addr), 32'h01);
    cyc(); settle();
    check("t3_rd_ack",    32'(table_rd_ack), 32'd1);
    check("t3_rd_data",   table_rd_data, 32'hDEADBEEF);
    check("t3_no_lkp_rsp", 32'(lookup_rsp_vld), 32'd0);
    table_rd_req = 1'b0;
    // A fresh request must wait the full limit again: the counter restarted.
    cyc(); table_rd_req = 1'b1; table_rd_addr = 8'h07; settle();
    count_denials(n_deny);
    check("t3_denials_2", 32'(n_deny), 32'(SL));
    check("t3_force_addr_2", 32'(mem_addr), 32'h07);
    cyc(); cyc(); settle();
    check("t3_rd_ack_2",  32'(table_rd_ack), 32'd1);
    check("t3_rd_data_2", table_rd_data, 32'h07070707);
    table_rd_req = 1'b0;
    lookup_req   = 1'b0;
    cyc(); cyc();

    // ---------------- simultaneous read and write ----------------
    cyc();
    table_wr_req = 1'b1; table_wr_addr = 8'h20; table_wr_data = 32'h55AA55AA;
    table_rd_req = 1'b1; table_rd_addr = 8'h21;
    settle();
    check("t4_wr_first",  32'(mem_we), 32'd1);
    check("t4_wr_addr",   32'(mem_addr), 32'h20);
    cyc(); settle();
    check("t4_wr_ack",    32'(table_wr_ack), 32'd1);
    check("t4_ack_cycle_idle", 32'(mem_en), 32'd0);
    table_wr_req = 1'b0;
    cyc(); settle();
    check("t4_rd_en",     32'(mem_en), 32'd1);
    check("t4_rd_we",     32'(mem_we), 32'd0);
    check("t4_rd_addr",   32'(mem_addr), 32'h21);
    cyc(); cyc(); settle();
    check("t4_rd_ack",    32'(table_rd_ack), 32'd1);
    check("t4_rd_data",   table_rd_data, 32'h21212121);
    table_rd_req = 1'b0;

    // ---------------- back-to-back lookups ----------------
    for (int c = 0; c < 6; c++) begin
      cyc();
      lookup_req  = (c < 3);
      lookup_addr = 8'(c + 1);
      settle();
      if (c < 3) check($sformatf("t5_gnt_%0d", c), 32'(lookup_gnt), 32'd1);
      if (c >= 2) check($sformatf("t5_vld_%0d", c), 32'(lookup_rsp_vld), 32'((c < 5) ? 1 : 0));
      if (c >= 2 && c < 5) check($sformatf("t5_data_%0d", c), lookup_rsp_data, b2b_exp[c-2]);
    end
    lookup_req = 1'b0;

    // ---------------- reset during an outstanding read ----------------
    cyc(); table_rd_req = 1'b1; table_rd_addr = 8'h05; settle();
    check("t6_gnt_en",    32'(mem_en), 32'd1);
    check("t6_gnt_addr",  32'(mem_addr), 32'h05);
    cyc(); reset = 1'b0; lookup_req = 1'b1; settle();
    check("t6_rst_gnt",   32'(lookup_gnt), 32'd0);
    check("t6_rst_en",    32'(mem_en), 32'd0);
    check("t6_rst_rdack", 32'(table_rd_ack), 32'd0);
    check("t6_rst_rsp_data", lookup_rsp_data, 32'd0);
    check("t6_rst_rd_data",  table_rd_data, 32'd0);
    cyc(); settle();
    check("t6_no_ack",    32'(table_rd_ack), 32'd0);
    check("t6_rst_en_2",  32'(mem_en), 32'd0);
    cyc(); lookup_req = 1'b0; reset = 1'b1; settle();
    check("t6_regrant_en",   32'(mem_en), 32'd1);
    check("t6_regrant_addr", 32'(mem_addr), 32'h05);
    check("t6_no_ack_rel",   32'(table_rd_ack), 32'd0);
    cyc(); settle();
    check("t6_ack_g1",    32'(table_rd_ack), 32'd0);
    cyc(); settle();
    check("t6_rd_ack",    32'(table_rd_ack), 32'd1);
    check("t6_rd_data",   table_rd_data, 32'h0000CAFE);
    table_rd_req = 1'b0;
    cyc(); settle();
    check("t6_ack_once",  32'(table_rd_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
